// File: rtl/reduce_rr_scheduler.sv
// Round-robin front end for a single shared reduction unit. One request is
// accepted in IDLE, reduced in EXEC and held in DONE until the consumer takes it.
module reduce_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int W     = 3,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_y,
    input  logic [N_REQ*W-1:0]   req_cin,
    input  logic [2*N_REQ-1:0]   req_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_result,
    output logic [IDW-1:0]       out_id,
    output logic [7:0]           done_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   cin_q, cin_d;
    logic [1:0]     op_q, op_d;
    logic           out_valid_q, out_valid_d;
    logic           out_result_q, out_result_d;
    logic [IDW-1:0] out_id_q, out_id_d;
    logic [7:0]     done_cnt_q, done_cnt_d;

    logic           found;
    logic [IDW-1:0] winner;
    logic           accept;
    logic [W-1:0]   a;
    logic           red;

    // Walk upward from ptr; the first valid requester wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

    assign accept    = (state_q == S_IDLE) && found && !rst;
    assign req_ready = accept ? (N_REQ'(1) << winner) : '0;

    // Op 11 is the De Morgan form of OR-reduce and must match op 01.
    always_comb begin
        a = y_q ^ cin_q;
        case (op_q)
            2'b00:   red = &a;
            2'b01:   red = |a;
            2'b10:   red = ^a;
            default: red = ~&(~a);
        endcase
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        y_d          = y_q;
        cin_d        = cin_q;
        op_d         = op_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_id_d     = out_id_q;
        done_cnt_d   = done_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    y_d     = req_y[int'(winner)*W +: W];
                    cin_d   = req_cin[int'(winner)*W +: W];
                    op_d    = req_op[int'(winner)*2 +: 2];
                    id_d    = winner;
                    ptr_d   = (int'(winner) == N_REQ-1) ? '0 : IDW'(int'(winner) + 1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                out_result_d = red;
                out_id_d     = id_q;
                out_valid_d  = 1'b1;
                state_d      = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    done_cnt_d  = done_cnt_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            y_q          <= '0;
            cin_q        <= '0;
            op_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_id_q     <= '0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            y_q          <= y_d;
            cin_q        <= cin_d;
            op_q         <= op_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_id_q     <= out_id_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_id     = out_id_q;
    assign done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_reduce_rr_scheduler.sv
// Transaction-level bench for reduce_rr_scheduler: directed scenarios followed
// by random traffic, all checked against a simple arbitration/reduction model.
module tb_reduce_rr_scheduler;
    localparam int N   = 4;
    localparam int W   = 3;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_y;
    logic [N*W-1:0] req_cin;
    logic [2*N-1:0] req_op;
    logic           out_valid;
    logic           out_ready;
    logic           out_result;
    logic [IDW-1:0] out_id;
    logic [7:0]     done_cnt;

    reduce_rr_scheduler #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_y(req_y), .req_cin(req_cin), .req_op(req_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_id(out_id), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    int mcnt  = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] ys[N];
    logic [W-1:0] cins[N];
    logic [1:0]   ops[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_y[i*W +: W]   = ys[i];
            req_cin[i*W +: W] = cins[i];
            req_op[i*2 +: 2]  = ops[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            ys[i]   = W'($urandom_range(0, (1 << W) - 1));
            cins[i] = W'($urandom_range(0, (1 << W) - 1));
            ops[i]  = 2'($urandom_range(0, 3));
        end
    endtask

    function automatic int ref_win(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    function automatic logic ref_red(input logic [1:0] op, input logic [W-1:0] y, input logic [W-1:0] c);
        logic [W-1:0] av, na;
        int ones;
        logic all_na;
        av = y ^ c;
        na = ~av;
        ones = 0;
        all_na = 1'b1;
        for (int b = 0; b < W; b++) begin
            ones += int'(av[b]);
            if (!na[b]) all_na = 1'b0;
        end
        case (op)
            2'd0:    return ones == W;
            2'd1:    return ones != 0;
            2'd2:    return (ones % 2) == 1;
            default: return !all_na;
        endcase
    endfunction

    // One full transfer: grant, exec, optional stall in DONE, then handover.
    task automatic txn(input logic [N-1:0] m, input int stall,
                       output int id_seen, output logic res_seen, output int ov_cyc);
        int w;
        logic er;
        @(negedge clk);
        drive_ops();
        req_valid = m;
        out_ready = 1'b0;
        #1;
        chk("idle_ovalid", 32'(out_valid), 0);
        chk("idle_cnt", 32'(done_cnt), 32'(mcnt));
        w = ref_win(m);
        id_seen = -1; res_seen = 1'b0; ov_cyc = cyc;
        if (w < 0) begin
            chk("ready_none", 32'(req_ready), 0);
            return;
        end
        chk("grant", 32'(req_ready), 32'(1 << w));
        er   = ref_red(ops[w], ys[w], cins[w]);
        mptr = (w + 1) % N;
        @(posedge clk);
        @(negedge clk);
        rand_ops();
        drive_ops();
        req_valid = '1;
        #1;
        chk("exec_ready", 32'(req_ready), 0);
        chk("exec_ovalid", 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        ov_cyc = cyc;
        chk("ovalid", 32'(out_valid), 1);
        chk("result", 32'(out_result), 32'(er));
        chk("id", 32'(out_id), 32'(w));
        chk("done_cnt_hold", 32'(done_cnt), 32'(mcnt));
        id_seen  = int'(out_id);
        res_seen = out_result;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("bp_ovalid", 32'(out_valid), 1);
            chk("bp_result", 32'(out_result), 32'(er));
            chk("bp_id", 32'(out_id), 32'(w));
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_cnt", 32'(done_cnt), 32'(mcnt));
        end
        out_ready = 1'b1;
        #1;
        chk("done_ready", 32'(req_ready), 0);
        @(posedge clk);
        mcnt = (mcnt + 1) % 256;
    endtask

    task automatic rst_mid(input bit in_done);
        int w;
        @(negedge clk);
        rand_ops();
        drive_ops();
        req_valid = '1;
        out_ready = 1'b0;
        #1;
        w = ref_win(4'hF);
        chk("rm_grant", 32'(req_ready), 32'(1 << w));
        @(posedge clk);
        @(negedge clk);
        if (in_done) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("rm_ovalid", 32'(out_valid), 0);
        chk("rm_cnt", 32'(done_cnt), 0);
        chk("rm_id", 32'(out_id), 0);
        chk("rm_res", 32'(out_result), 0);
        mptr = 0;
        mcnt = 0;
    endtask

    int   id_s, oc, prev_oc;
    logic r_s, r1, r3;

    initial begin
        rst = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        rand_ops();
        drive_ops();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_res", 32'(out_result), 0);
        chk("rst_id", 32'(out_id), 0);
        chk("rst_cnt", 32'(done_cnt), 0);
        rst = 1'b0;
        req_valid = '0;

        // Fairness: all requesting, then only 1 and 3
        prev_oc = 0;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            txn(4'b1111, 0, id_s, r_s, oc);
            chk("fair_id", 32'(id_s), 32'(k % 4));
            if (k > 0) chk("fair_ii", 32'(oc - prev_oc), 3);
            prev_oc = oc;
        end
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            txn(4'b1010, 0, id_s, r_s, oc);
            chk("alt_id", 32'(id_s), (k % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Single operation
        rand_ops();
        ys[0] = 3'b101; cins[0] = 3'b010; ops[0] = 2'b00;
        txn(4'b0001, 0, id_s, r_s, oc);
        chk("single_res", 32'(r_s), 1);
        chk("single_id", 32'(id_s), 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("single_cnt", 32'(done_cnt), 32'(mcnt));

        // Opcode sweep on requester 2
        ys[2] = 3'b110; cins[2] = 3'b000; ops[2] = 2'b10;
        txn(4'b0100, 0, id_s, r_s, oc);
        chk("xor_110", 32'(r_s), 0);
        ys[2] = 3'b000; cins[2] = 3'b000; ops[2] = 2'b11;
        txn(4'b0100, 0, id_s, r_s, oc);
        chk("dm_000", 32'(r_s), 0);
        ys[2] = 3'b100; cins[2] = 3'b000; ops[2] = 2'b11;
        txn(4'b0100, 0, id_s, r_s, oc);
        chk("dm_100", 32'(r_s), 1);
        for (int y = 0; y < 8; y++) begin
            for (int c = 0; c < 8; c++) begin
                ys[2] = W'(y); cins[2] = W'(c); ops[2] = 2'b01;
                txn(4'b0100, 0, id_s, r1, oc);
                ys[2] = W'(y); cins[2] = W'(c); ops[2] = 2'b11;
                txn(4'b0100, 0, id_s, r3, oc);
                chk("op1_eq_op3", 32'(r3), 32'(r1));
            end
        end

        // Backpressure with everyone requesting
        rand_ops();
        txn(4'b1111, 5, id_s, r_s, oc);

        // Reset during EXEC, then during a stalled DONE
        rst_mid(1'b0);
        rand_ops();
        txn(4'b1111, 0, id_s, r_s, oc);
        chk("post_rst_exec_id", 32'(id_s), 0);
        rst_mid(1'b1);
        rand_ops();
        txn(4'b1111, 0, id_s, r_s, oc);
        chk("post_rst_done_id", 32'(id_s), 0);

        // Random traffic; long enough to wrap done_cnt past 255
        for (int t = 0; t < 320; t++) begin
            rand_ops();
            txn(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), id_s, r_s, oc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reduce_rr_scheduler.md
# reduce_rr_scheduler

Round-robin scheduler that shares one registered reduction unit (AND/OR/XOR/De Morgan NAND-of-inverted) among N_REQ requesters. Each requester presents a W-bit operand pair and an opcode with a valid/ready handshake. The scheduler grants one requester at a time, evaluates the reduction on the XOR of the operand pair, and returns the 1-bit result tagged with the requester ID. Results are held under output backpressure. The block sits between the per-channel control logic and the shared reduce datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 3, operand width (1..16)
- IDW, $clog2(N_REQ), width of requester ID
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept (one-hot or zero)
- req_y  in  N_REQ*W  operand y, requester i at bits [i*W +: W]
- req_cin  in  N_REQ*W  operand cin, same packing
- req_op  in  2*N_REQ  opcode, requester i at [2*i +: 2]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  1  reduction result
- out_id  out  IDW  index of requester that produced out_result
- done_cnt  out  8  completed-transfer counter

## Operation
- States: IDLE, EXEC, DONE. Reset state IDLE.
- IDLE behavior:
  - Arbitration is round-robin. Search starts at pointer `ptr` and walks upward modulo N_REQ. The first i with req_valid[i]=1 wins.
  - req_ready[winner]=1 combinationally, and only in IDLE. All other bits are 0. All bits are 0 when no request is pending.
- Accept (IDLE and any req_valid):
  - Latch y, cin, op and the winner index.
  - ptr <= (winner+1) mod N_REQ.
  - Go to EXEC.
- EXEC:
  - a = y ^ cin (W bits).
  - Register result by opcode: 00 -> &a, 01 -> |a, 10 -> ^a, 11 -> ~&(~a). Op 11 must equal op 01 for all a.
  - Go to DONE.
- DONE:
  - out_valid=1. out_result and out_id are stable.
  - When out_ready=1: done_cnt <= done_cnt+1 (wraps 255->0) and go to IDLE.
  - No request is accepted in the same cycle as an output transfer.
- Requester rules:
  - A requester may drop req_valid before it is granted.
  - Its operands are sampled only on the accept edge.
  - Operand changes after accept have no effect.
- Reset values: req_ready=0, out_valid=0, out_result=0, out_id=0, done_cnt=0, ptr=0, state IDLE.
- Reset asserted in any state, including mid-EXEC or DONE with out_ready=0: the in-flight operation is discarded with no output transfer, and all reset values apply on the next cycle.
- ptr does not move while no request is accepted.

## Timing
- Accept edge T (IDLE, req_valid&req_ready). EXEC during cycle T+1. out_valid=1 from cycle T+2.
- Request-to-result latency is 2 cycles. Minimum initiation interval is 3 cycles (accept, exec, done+ready).
- out_valid stays high, and out_result/out_id hold, until the cycle with out_ready=1. out_valid drops the next cycle.
- req_ready is combinational from req_valid, ptr and state. All other outputs are registered.
- done_cnt updates on the edge ending the DONE cycle with out_ready=1.

## Test plan
- Single operation: N_REQ=4, W=3, req_valid=0001, y=101, cin=010, op=00, out_ready=1. Required: req_ready=0001 at T, out_valid=1 at T+2, result=1, id=0, done_cnt=1.
- Opcode sweep, exhaustive on requester 2:
  - y=110, cin=000, op=10 -> 0.
  - y=000, cin=000, op=11 -> 0.
  - y=100, cin=000, op=11 -> 1.
  - All 64 (y,cin) pairs: op01 == op11.
- Fairness: req_valid=1111 held, out_ready=1. Required: out_id sequence 0,1,2,3,0, one result every 3 cycles. Then req_valid=1010 -> ids alternate 1,3.
- Backpressure: out_ready=0 for 5 cycles in DONE with req_valid=1111. Required: out_valid, out_result, out_id stable; req_ready=0000; done_cnt unchanged.
- Reset mid-operation: rst=1 during EXEC, and separately during DONE with out_ready=0. Required: next cycle out_valid=0, done_cnt=0, and the next accept grants requester 0 first.
- Counter wrap: 256 completed transfers. Required: done_cnt reads 255 then 0.
